led_mode_sched: RTL

- Sequences the 2-bit LED pattern-select bus (`ctrl`) that drives the 8-bit LED pattern generator.
- Turns one raw push-button into two kinds of event:
  - short press: step to the next pattern;
  - long press: toggle auto-rotate mode.
- In auto-rotate mode the block advances the pattern on a fixed timer.
- Sits between the board key pin and the LED pattern block; runs on the 27 MHz system clock.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_mode_sched_if.sv | 13 +
 rtl/key_debounce.sv | 60 ++++++
 rtl/led_mode_sched.sv | 108 ++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and 27 MHz timing defaults for the LED mode scheduler and its key front end.
package led_pkg;

    typedef logic [1:0] ctrl_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    localparam int DB_CYCLES_27M   = 540000;     // 20 ms
    localparam int LONG_CYCLES_27M = 27000000;   // 1 s
    localparam int AUTO_CYCLES_27M = 54000000;   // 2 s

    // Counter width for a count of n states, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_mode_sched_if.sv
// Key input and pattern-select outputs between the board key, the scheduler and the LED pattern block.
interface led_mode_sched_if;
    import led_pkg::*;

    logic  key;
    ctrl_t ctrl;
    logic  auto_en;
    logic  ctrl_upd;

    modport master (input key, output ctrl, output auto_en, output ctrl_upd);
    modport slave  (output key, input ctrl, input auto_en, input ctrl_upd);

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser and debounce for one active-low push-button, with edge strobes on key_db.
module key_debounce
    import led_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_27M
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_db,
    output logic fall,
    output logic rise
);
    localparam int DB_W = cnt_width(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync;
    logic            key_s;
    logic            armed;
    logic            db_tc;
    logic            commit;
    logic [DB_W-1:0] db_cnt;

    assign key_s  = sync[1];
    assign db_tc  = (db_cnt == DB_TC);
    assign commit = armed && (key_s != key_db) && db_tc;
    assign fall   = commit && !key_s;
    assign rise   = commit && key_s;

    // Until the key has been seen stably released after reset, db_cnt measures that
    // release instead; a key held through reset therefore never produces a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= 2'b11;
            key_db <= 1'b1;
            armed  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync <= {sync[0], key_in};
            if (!armed) begin
                if (!key_s) begin
                    db_cnt <= '0;
                end else if (db_tc) begin
                    armed  <= 1'b1;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (db_tc) begin
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_mode_sched.sv
// LED pattern-select sequencer: short press steps ctrl, long press toggles timed auto-rotate.
//
//   state     | meaning
//   IDLE      | key released, waiting for a debounced press
//   PRESSED   | key down, hold_cnt timing the press
//   LONG_HELD | long press already taken, waiting for release
module led_mode_sched
    import led_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_27M,
    parameter int LONG_CYCLES = LONG_CYCLES_27M,
    parameter int AUTO_CYCLES = AUTO_CYCLES_27M
) (
    input logic              clk,
    input logic              rst,
    led_mode_sched_if.master bus
);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);
    localparam int AUTO_W = cnt_width(AUTO_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [AUTO_W-1:0] AUTO_TC = AUTO_W'(AUTO_CYCLES - 1);

    press_state_t      state, state_nxt;
    logic              key_db, key_fall, key_rise;
    logic [HOLD_W-1:0] hold_cnt;
    logic [AUTO_W-1:0] auto_cnt;
    logic              hold_tc, auto_tick, short_ev, long_ev, advance;
    ctrl_t             ctrl_q;
    logic              auto_q, upd_q;

    key_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_key_debounce (
        .clk    (clk),
        .rst    (rst),
        .key_in (bus.key),
        .key_db (key_db),
        .fall   (key_fall),
        .rise   (key_rise)
    );

    assign hold_tc   = (hold_cnt == HOLD_TC);
    assign auto_tick = auto_q && (auto_cnt == AUTO_TC);
    // A long press owns its cycle; a short press and an auto tick merge into one step.
    assign advance   = short_ev || (auto_tick && !long_ev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        short_ev  = 1'b0;
        long_ev   = 1'b0;
        case (state)
            IDLE: begin
                if (key_fall) state_nxt = PRESSED;
            end
            PRESSED: begin
                if (hold_tc && !key_db) begin
                    long_ev   = 1'b1;
                    state_nxt = key_rise ? IDLE : LONG_HELD;
                end else if (key_rise) begin
                    short_ev  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            LONG_HELD: begin
                if (key_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   hold_cnt <= '0;
        else if (state != PRESSED) hold_cnt <= '0;
        else if (!hold_tc)         hold_cnt <= hold_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            auto_q   <= 1'b0;
            upd_q    <= 1'b0;
            auto_cnt <= '0;
        end else begin
            upd_q <= advance;
            if (long_ev) begin
                auto_q   <= !auto_q;
                auto_cnt <= '0;
            end else if (advance) begin
                ctrl_q   <= ctrl_q + 2'd1;
                auto_cnt <= '0;
            end else if (auto_q) begin
                auto_cnt <= auto_cnt + 1'b1;
            end else begin
                auto_cnt <= '0;
            end
        end
    end

    assign bus.ctrl     = ctrl_q;
    assign bus.auto_en  = auto_q;
    assign bus.ctrl_upd = upd_q;

endmodule
